motion_delta_extractor: RTL and testbench



---
 rtl/gesture_pkg.sv | 28 ++
 rtl/motion_delta_extractor.sv | 152 +++++++++++++++
 tb/tb_motion_delta_extractor.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gesture_pkg.sv
// Shared types and constants for the gesture front end and classifier.
// Holds FSM/end-cause encodings, gesture codes, default widths and a signed-abs helper.
package gesture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_EMIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    typedef enum logic {
        CAUSE_RELEASE = 1'b0,
        CAUSE_TIMEOUT = 1'b1
    } end_cause_t;

    localparam logic [1:0] GEST_UP    = 2'd0;
    localparam logic [1:0] GEST_DOWN  = 2'd1;
    localparam logic [1:0] GEST_LEFT  = 2'd2;
    localparam logic [1:0] GEST_RIGHT = 2'd3;

    localparam int DEFAULT_DATA_BITS = 16;

    function automatic logic [31:0] abs_s(input logic signed [31:0] v);
        return (v < 0) ? $unsigned(-v) : $unsigned(v);
    endfunction

endpackage

// File: rtl/motion_delta_extractor.sv
// Purpose: turns absolute contact samples into one signed movement vector per stroke (MOTION_SMOOTH_EN: IIR-smoothed end point).
// Latency: delta_valid 2 cycles after the terminating sample.
// Backpressure: none; samples arriving in the one-cycle EMIT state are dropped.
module motion_delta_extractor
    import gesture_pkg::*;
#(
    parameter int COORD_BITS  = 10,
    parameter int DATA_BITS   = DEFAULT_DATA_BITS,
    parameter int MIN_SAMPLES = 4,
    parameter int MAX_SAMPLES = 64,
    parameter int DEADZONE    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_valid,
    input  logic [COORD_BITS-1:0] sample_x,
    input  logic [COORD_BITS-1:0] sample_y,
    input  logic                  contact,
    output logic                  delta_valid,
    output logic [DATA_BITS-1:0]  delta_x,
    output logic [DATA_BITS-1:0]  delta_y,
    output logic                  busy
);

    localparam int CNT_W = $clog2(MAX_SAMPLES + 1);

    state_t                       state_q, state_d;
    end_cause_t                   cause_q, cause_d;
    logic [COORD_BITS-1:0]        start_x_q, start_x_d, start_y_q, start_y_d;
    logic [COORD_BITS-1:0]        last_x_q, last_x_d, last_y_q, last_y_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         delta_valid_q, delta_valid_d;
    logic signed [DATA_BITS-1:0]  delta_x_q, delta_x_d, delta_y_q, delta_y_d;

    logic signed [DATA_BITS-1:0]  dx, dy;
    logic [COORD_BITS-1:0]        new_x, new_y;
    logic                         emit_ok;

`ifdef MOTION_SMOOTH_EN
    localparam int SW = COORD_BITS + 2;
    logic signed [SW-1:0] step_x, step_y, sum_x, sum_y;

    always_comb begin
        step_x = ($signed({2'b00, sample_x}) - $signed({2'b00, last_x_q})) >>> 2;
        step_y = ($signed({2'b00, sample_y}) - $signed({2'b00, last_y_q})) >>> 2;
        sum_x  = $signed({2'b00, last_x_q}) + step_x;
        sum_y  = $signed({2'b00, last_y_q}) + step_y;
    end

    assign new_x = sum_x[COORD_BITS-1:0];
    assign new_y = sum_y[COORD_BITS-1:0];
`else
    assign new_x = sample_x;
    assign new_y = sample_y;
`endif

    // Screen y grows downward; the classifier wants up as positive.
    assign dx = $signed(DATA_BITS'(last_x_q)) - $signed(DATA_BITS'(start_x_q));
    assign dy = $signed(DATA_BITS'(start_y_q)) - $signed(DATA_BITS'(last_y_q));

    assign emit_ok = (32'(count_q) >= 32'(MIN_SAMPLES)) &&
                     ((abs_s(32'(dx)) > 32'(DEADZONE)) || (abs_s(32'(dy)) > 32'(DEADZONE)));

    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        start_x_d     = start_x_q;
        start_y_d     = start_y_q;
        last_x_d      = last_x_q;
        last_y_d      = last_y_q;
        count_d       = count_q;
        delta_valid_d = 1'b0;
        delta_x_d     = delta_x_q;
        delta_y_d     = delta_y_q;

        case (state_q)
            ST_IDLE: begin
                if (sample_valid && contact) begin
                    start_x_d = sample_x;
                    start_y_d = sample_y;
                    last_x_d  = sample_x;
                    last_y_d  = sample_y;
                    count_d   = CNT_W'(1);
                    state_d   = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (sample_valid) begin
                    if (contact) begin
                        last_x_d = new_x;
                        last_y_d = new_y;
                        if (count_q != CNT_W'(MAX_SAMPLES))
                            count_d = count_q + CNT_W'(1);
                        if (count_q == CNT_W'(MAX_SAMPLES - 1)) begin
                            cause_d = CAUSE_TIMEOUT;
                            state_d = ST_EMIT;
                        end
                    end else begin
                        cause_d = CAUSE_RELEASE;
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (emit_ok) begin
                    delta_x_d     = dx;
                    delta_y_d     = dy;
                    delta_valid_d = 1'b1;
                end
                state_d = (cause_q == CAUSE_TIMEOUT) ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                // A timed-out stroke stays latched until the finger lifts.
                if (sample_valid && !contact)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cause_q       <= CAUSE_RELEASE;
            start_x_q     <= '0;
            start_y_q     <= '0;
            last_x_q      <= '0;
            last_y_q      <= '0;
            count_q       <= '0;
            delta_valid_q <= 1'b0;
            delta_x_q     <= '0;
            delta_y_q     <= '0;
        end else begin
            state_q       <= state_d;
            cause_q       <= cause_d;
            start_x_q     <= start_x_d;
            start_y_q     <= start_y_d;
            last_x_q      <= last_x_d;
            last_y_q      <= last_y_d;
            count_q       <= count_d;
            delta_valid_q <= delta_valid_d;
            delta_x_q     <= delta_x_d;
            delta_y_q     <= delta_y_d;
        end
    end

    assign delta_valid = delta_valid_q;
    assign delta_x     = delta_x_q;
    assign delta_y     = delta_y_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_motion_delta_extractor.sv
// Scoreboard bench for motion_delta_extractor: directed strokes plus random strokes.
module tb_motion_delta_extractor;
    localparam int CB   = 10;
    localparam int DB   = 16;
    localparam int MINS = 4;
    localparam int MAXS = 64;
    localparam int DZ   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_valid = 1'b0;
    logic          contact = 1'b0;
    logic [CB-1:0] sample_x = '0;
    logic [CB-1:0] sample_y = '0;
    logic          delta_valid;
    logic          busy;
    logic [DB-1:0] delta_x;
    logic [DB-1:0] delta_y;

    always #5 clk = ~clk;

    motion_delta_extractor #(
        .COORD_BITS(CB), .DATA_BITS(DB), .MIN_SAMPLES(MINS), .MAX_SAMPLES(MAXS), .DEADZONE(DZ)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_x(sample_x),
        .sample_y(sample_y), .contact(contact), .delta_valid(delta_valid),
        .delta_x(delta_x), .delta_y(delta_y), .busy(busy)
    );

    typedef struct {int dx; int dy; int cyc;} exp_t;
    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;
    int   cyc = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every pulse, flags missing/extra pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (delta_valid) begin
                pulses++;
                chk("no_back_to_back", int'(prev_v), 0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got dx=%0d dy=%0d expected no pulse", $signed(delta_x), $signed(delta_y));
                end else begin
                    mon_e = q.pop_front();
                    chk("delta_x", int'($signed(delta_x)), mon_e.dx);
                    chk("delta_y", int'($signed(delta_y)), mon_e.dy);
                    chk("latency_cycle", cyc, mon_e.cyc);
                end
            end else if (q.size() > 0 && cyc > q[0].cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_pulse: got none by cycle %0d expected dx=%0d dy=%0d", cyc, q[0].dx, q[0].dy);
                void'(q.pop_front());
            end
            prev_v = delta_valid;
        end
    end

    // Reference model: stroke rules stated as plain integer bookkeeping.
    int m_mode = 0;           // 0 waiting for contact, 1 in stroke, 2 latched after window limit
    int m_sx, m_sy, m_lx, m_ly, m_cnt;
    int m_term = -10;

    task automatic model_reset();
        m_mode = 0;
        m_term = -10;
    endtask

    task automatic model_end(input int dc, input bit timeout);
        int ddx, ddy;
        exp_t e;
        ddx = m_lx - m_sx;
        ddy = m_sy - m_ly;
        if (m_cnt >= MINS && ((ddx > DZ || -ddx > DZ) || (ddy > DZ || -ddy > DZ))) begin
            e.dx = ddx;
            e.dy = ddy;
            e.cyc = dc + 2;
            q.push_back(e);
        end
        m_term = dc;
        m_mode = timeout ? 2 : 0;
    endtask

    task automatic model(input int x, input int y, input bit c, input int dc);
        if (dc == m_term + 1) return;
        if (m_mode == 0) begin
            if (c) begin
                m_sx = x; m_sy = y; m_lx = x; m_ly = y; m_cnt = 1; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (c) begin
                m_lx = x; m_ly = y; m_cnt++;
                if (m_cnt == MAXS) model_end(dc, 1'b1);
            end else begin
                model_end(dc, 1'b0);
            end
        end else if (!c) begin
            m_mode = 0;
        end
    endtask

    task automatic send(input int x, input int y, input bit c);
        sample_valid = 1'b1;
        sample_x = CB'(x);
        sample_y = CB'(y);
        contact = c;
        model(x, y, c, cyc);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int clampc(input int v);
        return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
    endfunction

    int p0, n, bx, by, spread;

    initial begin
        // Reset held: inputs toggle, outputs must stay cleared.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            contact = i[0];
            sample_x = CB'($urandom);
            sample_y = CB'($urandom);
            #1;
            chk("rst_delta_valid", int'(delta_valid), 0);
            chk("rst_delta_x", int'(delta_x), 0);
            chk("rst_delta_y", int'(delta_y), 0);
            chk("rst_busy", int'(busy), 0);
        end
        sample_valid = 1'b0;
        contact = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle(3);
        chk("post_rst_pulses", pulses, 0);
        chk("post_rst_busy", int'(busy), 0);

        // Right swipe
        p0 = pulses;
        for (int i = 0; i < 5; i++) send(100 + 20 * i, 200, 1'b1);
        send(999, 999, 1'b0);
        idle(4);
        chk("swipe_pulses", pulses - p0, 1);
        chk("swipe_dx", int'($signed(delta_x)), 80);
        chk("swipe_dy", int'($signed(delta_y)), 0);

        // Short tap
        p0 = pulses;
        send(100, 50, 1'b1); send(200, 50, 1'b1); send(300, 50, 1'b1);
        send(300, 50, 1'b0);
        idle(4);
        chk("tap_pulses", pulses - p0, 0);
        chk("tap_busy", int'(busy), 0);

        // Dead zone
        p0 = pulses;
        for (int i = 0; i < 6; i++) send(500 + i, 300 - (i * 4) / 5, 1'b1);
        send(0, 0, 1'b0);
        idle(4);
        chk("deadzone_pulses", pulses - p0, 0);

        // Window-limit up-swipe, latched hold, then a left swipe
        p0 = pulses;
        for (int i = 0; i < 64; i++) send(50, 500 - 2 * i, 1'b1);
        idle(3);
        chk("timeout_pulses", pulses - p0, 1);
        chk("timeout_dx", int'($signed(delta_x)), 0);
        chk("timeout_dy", int'($signed(delta_y)), 126);
        chk("hold_busy", int'(busy), 1);
        for (int i = 0; i < 10; i++) send(50, 300, 1'b1);
        idle(3);
        chk("hold_pulses", pulses - p0, 1);
        send(50, 300, 1'b0);
        idle(2);
        for (int i = 0; i < 5; i++) send(400 - 25 * i, 100, 1'b1);
        send(0, 0, 1'b0);
        idle(4);
        chk("left_dx", int'($signed(delta_x)), -100);
        chk("left_pulses", pulses - p0, 2);

        // Reset mid-stroke aborts; the next stroke works
        p0 = pulses;
        send(10, 10, 1'b1); send(200, 10, 1'b1); send(400, 10, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        @(negedge clk);
        send(400, 10, 1'b0);
        idle(4);
        chk("abort_pulses", pulses - p0, 0);
        for (int i = 0; i < 5; i++) send(10 + 10 * i, 600, 1'b1);
        send(0, 0, 1'b0);
        idle(4);
        chk("after_abort_dx", int'($signed(delta_x)), 40);

        // Random strokes against the model
        for (int s = 0; s < 40; s++) begin
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 10);
            bx = $urandom_range(0, 1023);
            by = $urandom_range(0, 1023);
            spread = ($urandom_range(0, 1) == 1) ? 6 : 200;
            for (int i = 0; i < n; i++) begin
                send(clampc(bx + int'($urandom_range(0, 2 * spread)) - spread),
                     clampc(by + int'($urandom_range(0, 2 * spread)) - spread), 1'b1);
                idle($urandom_range(0, 2));
            end
            send($urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0);
            idle($urandom_range(0, 3));
        end
        idle(2);
        send(0, 0, 1'b0);
        idle(10);
        chk("queue_drained", q.size(), 0);
        chk("final_busy", int'(busy), (m_mode != 0) ? 1 : 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end
endmodule
